// File: rtl/stage2_maxpool.sv
// stage2_maxpool: streaming 2x2 / stride-2 max-pool with optional ReLU.
// Horizontal pair maxima of even rows are held in a line buffer for the odd row.
module stage2_maxpool #(
    parameter int CH    = 3,
    parameter int BW    = 16,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_in_valid,
    input  logic [CH*BW-1:0] i_in_fmap,
    output logic             o_ot_valid,
    output logic [CH*BW-1:0] o_ot_fmap,
    output logic             o_frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LD = IMG_W / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [CH*BW-1:0] h;
    logic [CH*BW-1:0] pair;
    logic [CH*BW-1:0] pool;
    logic [CH*BW-1:0] lb_rd;
    logic [CH*BW-1:0] lb [LD];
    logic [LW-1:0]    lb_idx;
    logic             last_col;
    logic             last_row;

    function automatic logic [BW-1:0] max2(input logic [BW-1:0] a,
                                           input logic [BW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [BW-1:0] clamp(input logic [BW-1:0] v);
        return (RELU != 0 && v[BW-1]) ? '0 : v;
    endfunction

    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    assign lb_idx   = LW'(col >> 1);
    assign lb_rd    = lb[lb_idx];

    always_comb begin
        pair = '0;
        pool = '0;
        for (int c = 0; c < CH; c++) begin
            pair[c*BW +: BW] = max2(h[c*BW +: BW], i_in_fmap[c*BW +: BW]);
            pool[c*BW +: BW] = clamp(max2(lb_rd[c*BW +: BW], pair[c*BW +: BW]));
        end
    end

    // Every entry is rewritten in an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (i_in_valid && col[0] && !row[0])
            lb[lb_idx] <= pair;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col          <= '0;
            row          <= '0;
            h            <= '0;
            o_ot_valid   <= 1'b0;
            o_ot_fmap    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_in_valid) begin
                if (!col[0])
                    h <= i_in_fmap;
                if (col[0] && row[0]) begin
                    o_ot_valid   <= 1'b1;
                    o_ot_fmap    <= pool;
                    o_frame_done <= last_col && last_row;
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage2_maxpool.sv
// tb_stage2_maxpool: random and directed frames against a window-level model.
// Two instances share the input stream: one with ReLU, one without.
module tb_stage2_maxpool;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CH = 3;
    localparam int BW = 16;

    logic          clk;
    logic          reset_n;
    logic          i_in_valid;
    logic [47:0]   i_in_fmap;
    logic          vr, vn, dr, dn;
    logic [47:0]   fr, fn;

    int total = 0;
    int bad   = 0;

    stage2_maxpool #(.CH(CH), .BW(BW), .IMG_W(W), .IMG_H(H), .RELU(1)) dut_r (
        .clk(clk), .reset_n(reset_n), .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap), .o_ot_valid(vr), .o_ot_fmap(fr),
        .o_frame_done(dr)
    );

    stage2_maxpool #(.CH(CH), .BW(BW), .IMG_W(W), .IMG_H(H), .RELU(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap), .o_ot_valid(vn), .o_ot_fmap(fn),
        .o_frame_done(dn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: the current frame as a picture, plus last pooled values
    logic [47:0] img [H][W];
    int          n;
    logic [47:0] held_r, held_n;
    int          pulses;
    logic [47:0] seen[$];
    int          done_at[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mk(input int v);
        logic [15:0] t;
        t = v[15:0];
        return {t, t, t};
    endfunction

    function automatic logic [47:0] window_max(input int r, input int c,
                                               input bit relu);
        logic [47:0]        res;
        logic signed [15:0] t;
        int                 m, v;
        res = '0;
        for (int ch = 0; ch < CH; ch++) begin
            t = img[r][c][ch*16 +: 16];
            m = t;
            for (int dr2 = 0; dr2 < 2; dr2++)
                for (int dc = 0; dc < 2; dc++) begin
                    t = img[r-dr2][c-dc][ch*16 +: 16];
                    v = t;
                    if (v > m) m = v;
                end
            if (relu && m < 0) m = 0;
            res[ch*16 +: 16] = m[15:0];
        end
        return res;
    endfunction

    task automatic step(input logic v, input logic [47:0] d);
        logic ev, ed;
        int   r, c;
        ev = 1'b0;
        ed = 1'b0;
        i_in_valid = v;
        i_in_fmap  = d;
        if (v) begin
            r = n / W;
            c = n % W;
            img[r][c] = d;
            if (r % 2 == 1 && c % 2 == 1) begin
                ev     = 1'b1;
                ed     = (n == W*H - 1);
                held_r = window_max(r, c, 1'b1);
                held_n = window_max(r, c, 1'b0);
            end
            n = (n + 1) % (W*H);
        end
        @(posedge clk);
        @(negedge clk);
        chk("valid_relu", 64'(vr), 64'(ev));
        chk("valid_norelu", 64'(vn), 64'(ev));
        chk("done_relu", 64'(dr), 64'(ed));
        chk("done_norelu", 64'(dn), 64'(ed));
        chk("fmap_relu", 64'(fr), 64'(held_r));
        chk("fmap_norelu", 64'(fn), 64'(held_n));
        if (vr) begin
            seen.push_back(fr);
            if (dr) done_at.push_back(pulses);
            pulses++;
        end
        i_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(vr | vn), 64'd0);
        chk("rst_fmap_r", 64'(fr), 64'd0);
        chk("rst_fmap_n", 64'(fn), 64'd0);
        chk("rst_done", 64'(dr | dn), 64'd0);
        n      = 0;
        held_r = '0;
        held_n = '0;
        repeat (2) @(negedge clk);
        chk("rst_hold_fmap", 64'(fr | fn), 64'd0);
        reset_n = 1'b1;
    endtask

    function automatic logic [47:0] pixel(input int kind, input int base,
                                          input int r, input int c);
        logic [15:0] c0, c1, c2;
        case (kind)
            0: return mk(base + r*W + c);
            1: return mk(base);
            2: return mk((r % 2 == 0 && c % 2 == 0) ? 32767 : -32768);
            3: begin
                c0 = (r % 2 == 0 && c % 2 == 0) ? 16'd100 : 16'd1;
                c1 = (r % 2 == 0 && c % 2 == 1) ? 16'd100 : 16'd1;
                c2 = (r % 2 == 1 && c % 2 == 1) ? 16'd100 : 16'd1;
                return {c2, c1, c0};
            end
            default: return {16'($urandom), 16'($urandom), 16'($urandom)};
        endcase
    endfunction

    task automatic send_frame(input int kind, input int base, input int gap);
        for (int k = 0; k < W*H; k++) begin
            step(1'b1, pixel(kind, base, k / W, k % W));
            if (gap > 0)
                repeat ($urandom_range(gap, 0))
                    step(1'b0, {16'($urandom), 16'($urandom), 16'($urandom)});
        end
    endtask

    task automatic clear_log();
        pulses = 0;
        seen.delete();
        done_at.delete();
    endtask

    initial begin
        reset_n    = 1'b1;
        i_in_valid = 1'b0;
        i_in_fmap  = '0;
        clear_log();
        #1;
        do_reset();

        clear_log();
        send_frame(0, 0, 0);
        chk("ramp_pulses", 64'(pulses), 64'd4);
        if (seen.size() == 4) begin
            chk("ramp_o0", 64'(seen[0]), 64'(mk(5)));
            chk("ramp_o1", 64'(seen[1]), 64'(mk(7)));
            chk("ramp_o2", 64'(seen[2]), 64'(mk(13)));
            chk("ramp_o3", 64'(seen[3]), 64'(mk(15)));
        end

        clear_log();
        send_frame(1, -3, 0);
        chk("neg_pulses", 64'(pulses), 64'd4);
        chk("neg_relu_out", 64'(fr), 64'd0);
        chk("neg_norelu_out", 64'(fn), 64'(mk(-3)));

        send_frame(2, 0, 0);
        chk("extreme_out", 64'(fr), 64'(mk(32767)));

        send_frame(3, 0, 0);
        chk("chan_indep", 64'(fr), 64'(mk(100)));

        clear_log();
        send_frame(0, 0, 5);
        chk("gap_pulses", 64'(pulses), 64'd4);
        if (seen.size() == 4)
            chk("gap_o3", 64'(seen[3]), 64'(mk(15)));

        for (int f = 0; f < 6; f++)
            send_frame(4, 0, (f % 2) * 3);

        for (int k = 0; k < 6; k++)
            step(1'b1, pixel(0, 0, k / W, k % W));
        @(negedge clk);
        do_reset();
        clear_log();
        send_frame(0, 0, 0);
        chk("mrst_pulses", 64'(pulses), 64'd4);
        if (seen.size() == 4) begin
            chk("mrst_o0", 64'(seen[0]), 64'(mk(5)));
            chk("mrst_o3", 64'(seen[3]), 64'(mk(15)));
        end

        clear_log();
        send_frame(0, 0, 0);
        send_frame(0, 100, 0);
        chk("b2b_pulses", 64'(pulses), 64'd8);
        chk("b2b_ndone", 64'(done_at.size()), 64'd2);
        if (done_at.size() == 2) begin
            chk("b2b_done_a", 64'(done_at[0]), 64'd3);
            chk("b2b_done_b", 64'(done_at[1]), 64'd7);
        end
        if (seen.size() == 8) begin
            chk("b2b_o4", 64'(seen[4]), 64'(mk(105)));
            chk("b2b_o7", 64'(seen[7]), 64'(mk(115)));
        end

        repeat (3) step(1'b0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
